// File: rtl/neuron_mac_accum.sv
// neuron_mac_accum: pipelined signed multiply-accumulate onto a bias, one result
// per packet, with saturate-or-wrap output, overflow flag and length-error flag.
module neuron_mac_accum #(
    parameter int DATA_W    = 8,
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [WEIGHT_W-1:0] in_weight,
    input  logic                in_last,
    input  logic [ACC_W-1:0]    bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_sum,
    output logic                out_ovf,
    output logic                out_len_err
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int BASE_W = (ACC_W > PROD_W) ? ACC_W : PROD_W;
    localparam int INT_W  = BASE_W + $clog2(MAX_TERMS) + 1;
    localparam int CNT_W  = $clog2(MAX_TERMS);

    localparam logic signed [INT_W-1:0] ACC_MAX =
        INT_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [INT_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    state_t state, state_d;

    logic             fire;
    logic             term_last;
    logic [CNT_W-1:0] beat_cnt;

    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;
    logic                     s1_len_err;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [ACC_W-1:0]  s1_bias;

    logic signed [INT_W-1:0] prod_ext;
    logic signed [INT_W-1:0] bias_ext;
    logic signed [INT_W-1:0] acc;
    logic                    s2_done;
    logic                    s2_len_err;

    logic             s3_done;
    logic             s3_ovf;
    logic             s3_len_err;
    logic [ACC_W-1:0] s3_sum;
    logic [ACC_W-1:0] sum_c;
    logic             ovf_c;

    assign fire      = in_valid && in_ready;
    // The MAX_TERMS-th beat closes the packet even without in_last.
    assign term_last = in_last || (beat_cnt == CNT_W'(MAX_TERMS - 1));
    assign out_valid = (state == HOLD);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (fire) state_d = term_last ? DRAIN : ACCUM;
            ACCUM: if (fire && term_last) state_d = DRAIN;
            DRAIN: if (s3_done) state_d = HOLD;
            HOLD:  if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
        end else begin
            state    <= state_d;
            in_ready <= (state_d == IDLE) || (state_d == ACCUM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (fire) begin
            beat_cnt <= term_last ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_len_err <= 1'b0;
            s1_prod    <= '0;
            s1_bias    <= '0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_first   <= (state == IDLE);
                s1_last    <= term_last;
                s1_len_err <= term_last && !in_last;
                s1_prod    <= $signed(in_data) * $signed(in_weight);
                if (state == IDLE) s1_bias <= $signed(bias);
            end
        end
    end

    assign prod_ext = {{(INT_W - PROD_W){s1_prod[PROD_W-1]}}, s1_prod};
    assign bias_ext = {{(INT_W - ACC_W){s1_bias[ACC_W-1]}}, s1_bias};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            s2_done    <= 1'b0;
            s2_len_err <= 1'b0;
        end else begin
            s2_done <= s1_valid && s1_last;
            if (s1_valid) begin
                acc <= s1_first ? bias_ext + prod_ext : acc + prod_ext;
            end
            if (s1_valid && s1_last) s2_len_err <= s1_len_err;
        end
    end

    always_comb begin
        ovf_c = 1'b0;
        sum_c = acc[ACC_W-1:0];
        if (acc > ACC_MAX) begin
            ovf_c = 1'b1;
            if (SATURATE) sum_c = ACC_MAX[ACC_W-1:0];
        end else if (acc < ACC_MIN) begin
            ovf_c = 1'b1;
            if (SATURATE) sum_c = ACC_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_done    <= 1'b0;
            s3_sum     <= '0;
            s3_ovf     <= 1'b0;
            s3_len_err <= 1'b0;
        end else begin
            s3_done <= s2_done;
            if (s2_done) begin
                s3_sum     <= sum_c;
                s3_ovf     <= ovf_c;
                s3_len_err <= s2_len_err;
            end
        end
    end

    // Result registers load only on entry to HOLD, so they stay put while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum     <= '0;
            out_ovf     <= 1'b0;
            out_len_err <= 1'b0;
        end else if (state == DRAIN && s3_done) begin
            out_sum     <= s3_sum;
            out_ovf     <= s3_ovf;
            out_len_err <= s3_len_err;
        end
    end

endmodule
